// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: full-speed line state encodings and shared timing constants
package usb_fs_pkg;
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;
  localparam int FS_OSR = 4;
  localparam int FS_STUFF_LIMIT = 6;
endpackage

// File: rtl/bit_clock_recovery_if.sv
// bit_clock_recovery_if: line_state_in in; line_state_out/line_state_valid/phase_lock out (slave = recovery side)
interface bit_clock_recovery_if;
  import usb_fs_pkg::*;
  line_state_t line_state_in;
  line_state_t line_state_out;
  logic        line_state_valid;
  logic        phase_lock;
  modport master (output line_state_in, input line_state_out, line_state_valid, phase_lock);
  modport slave (input line_state_in, output line_state_out, line_state_valid, phase_lock);
endinterface

// File: rtl/bcr_lock_monitor.sv
// bcr_lock_monitor: i_transition/i_in_window/i_strobe -> o_phase_lock via in-window edge and idle-strobe counters
module bcr_lock_monitor #(
  parameter int LOCK_EDGES = 3,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_transition,
  input  logic i_in_window,
  input  logic i_strobe,
  output logic o_phase_lock
);
  localparam int GW = $clog2(LOCK_EDGES + 1);
  localparam int IW = $clog2(LOCK_TIMEOUT + 1);
  logic [GW-1:0] r_good;
  logic [IW-1:0] r_idle;
  logic w_bad, w_timeout;
  assign w_bad = i_transition && !i_in_window;
  assign w_timeout = !i_transition && r_idle == IW'(LOCK_TIMEOUT);
  always_ff @(posedge clk)
    if (rst) begin
      r_good <= '0;
      r_idle <= '0;
      o_phase_lock <= 1'b0;
    end else begin
      r_idle <= i_transition ? '0 : (i_strobe && !w_timeout) ? r_idle + IW'(1) : r_idle;
      r_good <= (w_bad || w_timeout) ? '0 : (i_transition && r_good != GW'(LOCK_EDGES)) ? r_good + GW'(1) : r_good;
      o_phase_lock <= (w_bad || w_timeout) ? 1'b0 : (r_good == GW'(LOCK_EDGES)) ? 1'b1 : o_phase_lock;
    end
endmodule

// File: rtl/bit_clock_recovery.sv
// bit_clock_recovery: clk/rst + slave bus; centre-samples oversampled line state, BCR_DEGLITCH_EN adds a 2-clock stability filter
module bit_clock_recovery
  import usb_fs_pkg::*;
#(
  parameter int OSR = FS_OSR,
  parameter int LOCK_EDGES = 3,
  parameter int LOCK_TIMEOUT = 8
) (
  input logic clk,
  input logic rst,
  bit_clock_recovery_if.slave bus
);
  localparam int PW = $clog2(OSR);
  line_state_t r_s1, r_s2, r_out, w_in;
  logic [PW-1:0] r_p, w_e;
  logic r_valid, w_transition, w_in_window, w_sample, w_lock;
`ifdef BCR_DEGLITCH_EN
  line_state_t r_dg;
  always_ff @(posedge clk) r_dg <= rst ? LS_J : bus.line_state_in;
  assign w_in = (bus.line_state_in == r_dg) ? r_dg : r_s1;
`else
  assign w_in = bus.line_state_in;
`endif
  assign w_transition = r_s1 != r_s2;
  assign w_e = w_transition ? '0 : r_p;
  assign w_sample = w_e == PW'(OSR / 2);
  assign w_in_window = r_p == PW'(OSR - 1) || r_p <= PW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      r_s1 <= LS_J;
      r_s2 <= LS_J;
      r_p <= '0;
      r_out <= LS_J;
      r_valid <= 1'b0;
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
      r_p <= (w_e == PW'(OSR - 1)) ? '0 : w_e + PW'(1);
      r_valid <= w_sample;
      r_out <= w_sample ? r_s1 : r_out;
    end
  bcr_lock_monitor #(
    .LOCK_EDGES(LOCK_EDGES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock (
    .clk(clk),
    .rst(rst),
    .i_transition(w_transition),
    .i_in_window(w_in_window),
    .i_strobe(w_sample),
    .o_phase_lock(w_lock)
  );
  assign bus.line_state_out = r_out;
  assign bus.line_state_valid = r_valid;
  assign bus.phase_lock = w_lock;
endmodule

// File: tb/tb_bit_clock_recovery.sv
// tb_bit_clock_recovery: scoreboard bench for bit_clock_recovery
module tb_bit_clock_recovery;
  import usb_fs_pkg::*;
`ifdef BCR_DEGLITCH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int DG = LAT - 4;
  typedef struct packed {
    logic [1:0] v;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_free = 0;
  int last = -1;
  bit free = 1'b1;
  exp_t q[$];
  exp_t e_m;
  bit_clock_recovery_if bus();
  bit_clock_recovery dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input line_state_t v, input int len, input int n);
    bus.line_state_in = v;
    for (int k = 0; k < n; k++) q.push_back(exp_t'{v, cyc + LAT + 4 * k});
    for (int k = 0; k < len; k++) begin
      tick();
      if (k == 1) free = 1'b0;
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.line_state_valid === 1'b1) begin
      if (free) begin
        n_free++;
        chk("idle_val", bus.line_state_out, LS_J);
        if (last >= 0) chk("idle_period", cyc - last, 4);
        last = cyc;
      end else if (q.size() == 0)
        chk("extra_strobe", bus.line_state_valid, 0);
      else begin
        e_m = q.pop_front();
        chk("strobe_val", bus.line_state_out, e_m.v);
        chk("strobe_lat", cyc, e_m.t);
      end
    end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.line_state_in = LS_J;
    repeat (3) tick();
    chk("rst_out", bus.line_state_out, LS_J);
    chk("rst_valid", bus.line_state_valid, 0);
    chk("rst_lock", bus.phase_lock, 0);
    rst = 1'b0;
    repeat (20 - DG) tick();
    chk("idle_count", n_free, 5 - DG);
    chk("idle_lock", bus.phase_lock, 0);
    send(LS_K, 4, 1);
    send(LS_J, 4, 1);
    chk("sync_lock2", bus.phase_lock, 0);
    send(LS_K, 4, 1);
    chk("sync_lock3", bus.phase_lock, 1);
    send(LS_J, 4, 1);
    send(LS_K, 4, 1);
    send(LS_J, 4, 1);
    send(LS_K, 8, 2);
    chk("sync_lock_end", bus.phase_lock, 1);
    for (int i = 0; i < 4; i++) begin
      send(LS_J, 3, 1);
      chk("jit_lock3", bus.phase_lock, 1);
      send(LS_K, 5, 1);
      chk("jit_lock5", bus.phase_lock, 1);
    end
    send(LS_J, 6, 1);
    bus.line_state_in = LS_K;
    q.push_back(exp_t'{LS_K, cyc + LAT});
    repeat (1 + DG) tick();
    chk("bad_lock_hold", bus.phase_lock, 1);
    tick();
    chk("bad_lock_drop", bus.phase_lock, 0);
    repeat (2 - DG) tick();
    send(LS_J, 4, 1);
    send(LS_K, 4, 1);
    chk("relock_pre", bus.phase_lock, 0);
    send(LS_J, 4, 1);
    chk("relock", bus.phase_lock, 1);
    send(LS_SE0, 8, 2);
    chk("se0_lock", bus.phase_lock, 1);
    send(LS_J, 28, 7);
    chk("idle7_lock", bus.phase_lock, 1);
    send(LS_J, 8, 2);
    chk("idle9_lock", bus.phase_lock, 0);
    send(LS_J, 8, 2);
    for (int i = 0; i < 16 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
    send(LS_K, 4, 1);
    send(LS_J, 4, 1);
    send(LS_K, 4, 1);
    bus.line_state_in = LS_J;
    repeat (2) tick();
    rst = 1'b1;
    free = 1'b1;
    last = -1;
    q.delete();
    tick();
    chk("mid_rst_out", bus.line_state_out, LS_J);
    chk("mid_rst_valid", bus.line_state_valid, 0);
    chk("mid_rst_lock", bus.phase_lock, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", bus.line_state_valid, 0);
    n_free = 0;
    repeat (16) tick();
    chk("post_rst_count", n_free, 4);
    chk("post_rst_lock", bus.phase_lock, 0);
`ifdef BCR_DEGLITCH_EN
    n_free = 0;
    bus.line_state_in = LS_K;
    tick();
    bus.line_state_in = LS_J;
    repeat (16) tick();
    chk("glitch_count", n_free, 4);
    chk("glitch_lock", bus.phase_lock, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bit_clock_recovery.md
Name: bit_clock_recovery

Overview:
Recovers the 12 Mb/s full-speed bit timing from the 48 MHz oversampled, already-synchronised line state. Emits one centre-sampled line state per bit period with a one-cycle valid strobe, plus a phase_lock indication. Sits between the line state detector and the EOP detector / NRZI decoder, which consume line_state_out, line_state_valid and phase_lock directly.

Parameters:
OSR, 4, clocks per bit period; even, >= 4
LOCK_EDGES, 3, consecutive in-window transitions required to assert phase_lock
LOCK_TIMEOUT, 8, bit strobes without any transition before phase_lock drops (must exceed 7, the bit-stuffing maximum)

Ports:
clk  input  1  48 MHz reference clock; one clock domain only
rst  input  1  synchronous, active-high reset
line_state_in  input  2  synchronised line state: 00 SE0, 01 J, 10 K, 11 SE1
line_state_out  output  2  line state sampled at bit centre
line_state_valid  output  1  one-cycle strobe, once per bit period
phase_lock  output  1  bit timing tracked and stable

Behaviour:
- Input pipeline: s1 <= line_state_in; s2 <= s1. transition = (s1 != s2).
- Phase register p counts 0..OSR-1.
- Effective phase: e = transition ? 0 : p.
- Next phase: p <= (e+1) mod OSR. Every transition re-centres timing; there is no gradual DPLL slew.
- Sampling: when e == OSR/2, the next cycle gives line_state_out <= s1 and line_state_valid <= 1. Otherwise line_state_valid <= 0 and line_state_out holds its value.
- Latency: a line change at the input in cycle n gives its first valid strobe in cycle n+4 (OSR=4).
- Strobe rate: exactly one strobe per OSR cycles while no transition arrives. Strobes are emitted regardless of phase_lock.
- Edge window: a transition is in-window when p is in {OSR-1, 0, 1}; otherwise it is out-of-window.
- Out-of-window edge: may drop or duplicate one strobe. This is accepted, and lock is dropped.
- Lock counter good (saturates at LOCK_EDGES):
  - in-window edge: good++
  - out-of-window edge: good <= 0, phase_lock <= 0
  - good reaching LOCK_EDGES: phase_lock <= 1 in the following cycle
- Idle counter: counts strobes since the last transition and clears on a transition. When it reaches LOCK_TIMEOUT: phase_lock <= 0, good <= 0, and the counter holds. Long idle J therefore unlocks; SYNC (KJKJKJKK) relocks.
- Simultaneous timeout strobe and transition: the transition wins (counter cleared, no timeout).
- SE0 and SE1 are sampled and passed through like J/K. Transitions between any two states count as edges.
- Reset, also mid-packet:
  - s1 = s2 = 01 (J, so no spurious edge); p = 0; counters = 0
  - line_state_out = 01, line_state_valid = 0, phase_lock = 0
  - reset overrides all other activity in the same cycle.

Optional Feature:
Macro BCR_DEGLITCH_EN.
- Defined: an additional stage between line_state_in and s1. A new state is accepted only after it is stable for 2 consecutive clocks, so single-cycle glitches are rejected. Adds 1 cycle to all latencies (n+5).
- Not defined: no filter stage; latency as above.

Decomposition:
- Shared package usb_fs_pkg:
  - line state typedef (SE0, J, K, SE1 encodings)
  - constants FS_OSR=4, FS_STUFF_LIMIT=6
- One natural sub-module: bcr_lock_monitor. It takes transition, in_window and strobe, owns the good/idle counters, and drives phase_lock.
- The deglitch stage stays inline under the macro.

Test Plan:
- Idle J after reset: line_state_valid pulses every 4 clocks, line_state_out = 01, phase_lock stays 0.
- SYNC KJKJKJKK at exact 4-clock bits: 8 strobes with values K,J,K,J,K,J,K,K; phase_lock = 1 after the 3rd edge; each strobe lands 3 cycles after its edge.
- Bit length jitter, alternating 3- and 5-clock bits: all edges in-window, no strobe lost or duplicated, phase_lock stays 1.
- Edge injected 2 clocks off phase while locked: phase_lock -> 0 the next cycle; it relocks after 3 clean edges.
- Packet tail SE0,SE0,J then 10 bits idle J: strobes 00,00,01 are delivered; phase_lock drops after the 8th strobe without a transition.
- rst pulsed mid-SYNC: outputs return to 01/0/0 the next cycle and no spurious strobe or edge occurs. With BCR_DEGLITCH_EN, a 1-clock K glitch on idle J produces no transition and no value change.
